mem_arbiter: RTL

Two-master arbiter and sequencer for the shared single-port data/instruction RAM. It accepts fetch requests from the IFU and load/store requests from the LSU over valid/ready handshakes. Requests are serialised onto one memory port with a fixed, parameterised read latency, and each response is returned to the master that issued it. It sits between the IFU/LSU and the RAM, replacing their direct dual-read-port access.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU/LSU request-response channels and the shared RAM port of mem_arbiter.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [ADDR_WIDTH-1:0] ifu_addr;
   logic [DATA_WIDTH-1:0] ifu_rdata;
   logic                  lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready, lsu_we;
   logic [1:0]            lsu_format;
   logic [ADDR_WIDTH-1:0] lsu_addr;
   logic [DATA_WIDTH-1:0] lsu_wdata, lsu_rdata;
   logic                  mem_en, mem_we, busy;
   logic [1:0]            mem_format;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
   modport slave (
      input  ifu_req_valid, ifu_addr, ifu_resp_ready,
             lsu_req_valid, lsu_we, lsu_format, lsu_addr, lsu_wdata, lsu_resp_ready, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
             lsu_req_ready, lsu_resp_valid, lsu_rdata,
             mem_en, mem_we, mem_format, mem_addr, mem_wdata, busy
   );
   modport master (
      output ifu_req_valid, ifu_addr, ifu_resp_ready,
             lsu_req_valid, lsu_we, lsu_format, lsu_addr, lsu_wdata, lsu_resp_ready, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
             lsu_req_ready, lsu_resp_valid, lsu_rdata,
             mem_en, mem_we, mem_format, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU fetches and LSU loads/stores onto one fixed-latency RAM port.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t                state_q, state_d;
   logic                  owner_q, owner_d, we_q, we_d;
   logic [1:0]            fmt_q, fmt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  gnt_lsu, gnt_ifu, idle, hs, resp_rdy;
`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_q, last_d;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         fmt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         fmt_q   <= fmt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end
   // owner/last_grant: 1 = LSU, 0 = IFU
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_q);
`else
      gnt_lsu = bus.lsu_req_valid;
`endif
      gnt_ifu  = bus.ifu_req_valid & ~gnt_lsu;
      idle     = (state_q == IDLE) & ~rst;
      hs       = idle & (gnt_lsu | gnt_ifu);
      resp_rdy = owner_q ? bus.lsu_resp_ready : bus.ifu_resp_ready;
      case (state_q)
         IDLE:    state_d = hs ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         default: state_d = resp_rdy ? IDLE : RESP;
      endcase
      owner_d = hs ? gnt_lsu : owner_q;
      we_d    = hs ? gnt_lsu & bus.lsu_we : we_q;
      fmt_d   = hs ? (gnt_lsu ? bus.lsu_format : 2'b10) : fmt_q;
      addr_d  = hs ? (gnt_lsu ? bus.lsu_addr : bus.ifu_addr) : addr_q;
      wdata_d = hs ? (gnt_lsu ? bus.lsu_wdata : '0) : wdata_q;
      cnt_d   = (state_q == ISSUE) ? 4'(MEM_LATENCY) : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
      rdata_d = (state_q == WAIT && cnt_q == 4'd1) ? (we_q ? '0 : bus.mem_rdata) : rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  = hs ? gnt_lsu : last_q;
`endif
   end
   always_comb begin
      bus.ifu_req_ready  = idle & gnt_ifu;
      bus.lsu_req_ready  = idle & gnt_lsu;
      bus.ifu_resp_valid = (state_q == RESP) & ~owner_q;
      bus.lsu_resp_valid = (state_q == RESP) & owner_q;
      bus.ifu_rdata      = rdata_q;
      bus.lsu_rdata      = rdata_q;
      bus.mem_en         = state_q == ISSUE;
      bus.mem_we         = (state_q == ISSUE) & we_q;
      bus.mem_format     = fmt_q;
      bus.mem_addr       = addr_q;
      bus.mem_wdata      = wdata_q;
      bus.busy           = state_q != IDLE;
   end
endmodule
